ctrl_sequencer: RTL

//  Control sequencer driving the reg_file_alu datapath; it generates the datapath's control inputs.

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/seq_decoder.sv | 58 +++++
 rtl/ctrl_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the control sequencer: opcodes, FSM states,
// ALU control encodings and instruction field positions.
package seq_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAnd  = 4'h1,
    OpOr   = 4'h2,
    OpAdd  = 4'h3,
    OpSub  = 4'h4,
    OpAndi = 4'h5,
    OpOri  = 4'h6,
    OpAddi = 4'h7,
    OpSubi = 4'h8,
    OpHalt = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2,
    StHalt = 2'd3
  } state_e;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned IMM_MSB = 7;

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decoder: maps a 16-bit instruction word onto the
// datapath control fields plus write/halt/illegal classification.
module seq_decoder
  import seq_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [15:0]   instr_i,
  output logic [3:0]    ra1_o,
  output logic [3:0]    ra2_o,
  output logic [3:0]    wa_o,
  output logic [1:0]    alu_ctrl_o,
  output logic          alu_src_o,
  output logic [DW-1:0] imm_o,
  output logic          writes_o,
  output logic          is_halt_o,
  output logic          is_illegal_o
);

  logic [3:0] op, rd, rs1, rs2;
  logic [3:0] op_m1, op_m5;

  assign op    = instr_i[OP_MSB:OP_LSB];
  assign rd    = instr_i[RD_MSB:RD_LSB];
  assign rs1   = instr_i[RS1_MSB:RS1_LSB];
  assign rs2   = instr_i[RS2_MSB:RS2_LSB];
  assign op_m1 = op - 4'd1;
  assign op_m5 = op - 4'd5;

  always_comb begin
    ra1_o        = rs1;
    ra2_o        = rs2;
    wa_o         = rd;
    alu_ctrl_o   = ALU_AND;
    alu_src_o    = 1'b0;
    imm_o        = DW'(instr_i[IMM_MSB:0]);
    writes_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (op)
      OpNop: ;
      OpAnd, OpOr, OpAdd, OpSub: begin
        alu_ctrl_o = op_m1[1:0];
        writes_o   = 1'b1;
      end
      // Immediate forms read and write the same register.
      OpAndi, OpOri, OpAddi, OpSubi: begin
        ra1_o      = rd;
        alu_ctrl_o = op_m5[1:0];
        alu_src_o  = 1'b1;
        writes_o   = 1'b1;
      end
      OpHalt:  is_halt_o    = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control sequencer for the reg_file_alu datapath: accepts instructions, issues
// registered control fields and a one-cycle RegWrite. Option: SEQ_ILLEGAL_CNT_EN.
module ctrl_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [3:0]       RA1,
  output logic [3:0]       RA2,
  output logic [3:0]       WA,
  output logic [1:0]       ALUControl,
  output logic             ALUSrc,
  output logic [DW-1:0]    imm_data,
  output logic             RegWrite,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
`ifdef SEQ_ILLEGAL_CNT_EN
  output logic [7:0]       illegal_cnt,
`endif
  output logic             illegal
);

  state_e state_q, state_d, accept_state;

  logic [3:0]       ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic [1:0]       alu_q, alu_d;
  logic             src_q, src_d;
  logic [DW-1:0]    imm_q, imm_d;
  logic             writes_q, writes_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0]    dec_ra1, dec_ra2, dec_wa;
  logic [1:0]    dec_alu;
  logic          dec_src, dec_writes, dec_halt, dec_illegal;
  logic [DW-1:0] dec_imm;
  logic          accept, issue;

  seq_decoder #(
    .DW (DW)
  ) u_decoder (
    .instr_i      (instr),
    .ra1_o        (dec_ra1),
    .ra2_o        (dec_ra2),
    .wa_o         (dec_wa),
    .alu_ctrl_o   (dec_alu),
    .alu_src_o    (dec_src),
    .imm_o        (dec_imm),
    .writes_o     (dec_writes),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_illegal)
  );

  assign accept = instr_valid & instr_ready;
  assign issue  = accept & ~dec_halt & ~dec_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ra1_q     <= '0;
      ra2_q     <= '0;
      wa_q      <= '0;
      alu_q     <= '0;
      src_q     <= 1'b0;
      imm_q     <= '0;
      writes_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ra1_q     <= ra1_d;
      ra2_q     <= ra2_d;
      wa_q      <= wa_d;
      alu_q     <= alu_d;
      src_q     <= src_d;
      imm_q     <= imm_d;
      writes_q  <= writes_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    if (dec_halt)         accept_state = StHalt;
    else if (dec_illegal) accept_state = StIdle;
    else                  accept_state = StExec;

    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = accept_state;
      StExec: state_d = StWb;
      StWb:   state_d = accept ? accept_state : StIdle;
      StHalt: state_d = StHalt;
    endcase
  end

  // Control registers only move on an issued ALU/NOP instruction.
  always_comb begin
    ra1_d     = ra1_q;
    ra2_d     = ra2_q;
    wa_d      = wa_q;
    alu_d     = alu_q;
    src_d     = src_q;
    imm_d     = imm_q;
    writes_d  = writes_q;
    if (issue) begin
      ra1_d    = dec_ra1;
      ra2_d    = dec_ra2;
      wa_d     = dec_wa;
      alu_d    = dec_alu;
      src_d    = dec_src;
      imm_d    = dec_imm;
      writes_d = dec_writes;
    end
    illegal_d = accept & dec_illegal;
    retired_d = (state_q == StWb) ? retired_q + CNT_W'(1) : retired_q;
  end

`ifdef SEQ_ILLEGAL_CNT_EN
  logic [7:0] ill_cnt_q, ill_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_cnt_q <= '0;
    else        ill_cnt_q <= ill_cnt_d;
  end

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (accept && dec_illegal && ill_cnt_q != 8'hFF) ill_cnt_d = ill_cnt_q + 8'd1;
  end

  assign illegal_cnt = ill_cnt_q;
`endif

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    instr_ready = rst_n & ((state_q == StIdle) | (state_q == StWb));
    RegWrite    = (state_q == StWb) & writes_q;
    halted      = (state_q == StHalt);
    RA1         = ra1_q;
    RA2         = ra2_q;
    WA          = wa_q;
    ALUControl  = alu_q;
    ALUSrc      = src_q;
    imm_data    = imm_q;
    retired     = retired_q;
    illegal     = illegal_q;
  end

endmodule
